// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - divider state encodings, issue FSM encodings and default widths
package div_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int TAG_W_DEF  = 3;

    // One-hot state reported by the divider unit
    localparam logic [2:0] DIV_INITIAL = 3'b001;
    localparam logic [2:0] DIV_COMPUTE = 3'b010;
    localparam logic [2:0] DIV_DONE    = 3'b100;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LAUNCH = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_BCAST  = 4'b1000
    } issue_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - request FIFO with flush; a pop frees its slot only on the following cycle
module div_req_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    // full is taken from the registered count, so a same-cycle pop never makes room for a push
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // Storage write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (do_push) mem_d[wr_ptr_q] = push_data;
    end

    // Control registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy qualifies it
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - divide issue controller: queue, Start/Ack launch, CDB broadcast (option: DIV_ZERO_CHECK_EN)
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_x,
    input  logic [DATA_W-1:0] req_y,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              flush,
    output logic              div_start,
    output logic              div_ack,
    output logic [DATA_W-1:0] div_xin,
    output logic [DATA_W-1:0] div_yin,
    output logic [TAG_W-1:0]  div_tag_in,
    input  logic [2:0]        div_state,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder,
    input  logic [TAG_W-1:0]  div_tag_out,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_quotient,
    output logic [DATA_W-1:0] cdb_remainder
);

    localparam int ENTRY_W = 2*DATA_W + TAG_W;

    issue_state_e      state_q, state_d;
    logic              drain_q, drain_d;
    logic              zchk_q, zchk_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_quot_q, cdb_quot_d;
    logic [DATA_W-1:0] cdb_rem_q, cdb_rem_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head_data;
    logic [DATA_W-1:0] head_x, head_y;
    logic [TAG_W-1:0]  head_tag;
    logic              zero_head;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready && !flush;
    assign {head_x, head_y, head_tag} = head_data;

    // The divider samples its operands in INITIAL, so the queue head is always presented
    assign div_xin    = head_x;
    assign div_yin    = head_y;
    assign div_tag_in = head_tag;

    assign cdb_tag       = cdb_tag_q;
    assign cdb_quotient  = cdb_quot_q;
    assign cdb_remainder = cdb_rem_q;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_head = (head_y == '0);
`else
    assign zero_head = 1'b0;
`endif

    div_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (fifo_push),
        .push_data ({req_x, req_y, req_tag}),
        .pop       (fifo_pop),
        .flush     (flush),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM: launch, wait for DONE, hold result on CDB until granted, then ack
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        zchk_d     = zchk_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_quot_d = cdb_quot_q;
        cdb_rem_d  = cdb_rem_q;
        fifo_pop   = 1'b0;
        div_start  = 1'b0;
        div_ack    = 1'b0;
        cdb_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !fifo_empty) begin
                    if (zero_head) begin
                        // Divide by zero is answered locally; the divider never sees it
                        fifo_pop   = 1'b1;
                        cdb_quot_d = '1;
                        cdb_rem_d  = head_x;
                        cdb_tag_d  = head_tag;
                        zchk_d     = 1'b1;
                        state_d    = ST_BCAST;
                    end else if (div_state == DIV_INITIAL) begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_start = 1'b1;
                    fifo_pop  = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_state == DIV_DONE) begin
                    if (drain_q || flush) begin
                        // Flushed work: release the divider without broadcasting
                        div_ack = 1'b1;
                        drain_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cdb_quot_d = div_quotient;
                        cdb_rem_d  = div_remainder;
                        cdb_tag_d  = div_tag_out;
                        state_d    = ST_BCAST;
                    end
                end else if (flush) begin
                    drain_d = 1'b1;
                end
            end
            ST_BCAST: begin
                if (flush) begin
                    div_ack = !zchk_q;
                    zchk_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cdb_valid = 1'b1;
                    if (cdb_grant) begin
                        div_ack = !zchk_q;
                        zchk_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and CDB result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            drain_q    <= 1'b0;
            zchk_q     <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_quot_q <= '0;
            cdb_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            zchk_q     <= zchk_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_quot_q <= cdb_quot_d;
            cdb_rem_q  <= cdb_rem_d;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl with a behavioural divider and result scoreboard
module tb_div_issue_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0, req_y = '0;
    logic [2:0] req_tag = '0;
    logic       flush = 1'b0;
    logic       div_start, div_ack;
    logic [7:0] div_xin, div_yin;
    logic [2:0] div_tag_in;
    logic [2:0] dstate;
    logic [7:0] dq, dr, dx, dy;
    logic [2:0] dtag;
    logic       cdb_valid;
    logic       cdb_grant = 1'b0;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_quotient, cdb_remainder;

    int checks = 0, failures = 0;
    int start_cnt = 0, ack_cnt = 0, vld_cnt = 0;
    int lat_fixed = 0;
    int dcnt;

    typedef struct packed {
        logic [2:0] tag;
        logic [7:0] q;
        logic [7:0] r;
    } res_t;
    res_t exp_q[$];

    div_issue_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .flush(flush),
        .div_start(div_start), .div_ack(div_ack),
        .div_xin(div_xin), .div_yin(div_yin), .div_tag_in(div_tag_in),
        .div_state(dstate), .div_quotient(dq), .div_remainder(dr), .div_tag_out(dtag),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag), .cdb_quotient(cdb_quotient), .cdb_remainder(cdb_remainder)
    );

    always #5 Clk = ~Clk;

    // Behavioural divider: latches operands on Start, finishes after a few cycles, waits for Ack
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dstate <= 3'b001; dcnt <= 0; dq <= '0; dr <= '0; dtag <= '0; dx <= '0; dy <= '0;
        end else begin
            case (dstate)
                3'b001: if (div_start) begin
                    dx <= div_xin; dy <= div_yin; dtag <= div_tag_in;
                    dcnt <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
                    dstate <= 3'b010;
                end
                3'b010: if (dy != 0) begin
                    if (dcnt <= 1) begin dq <= dx / dy; dr <= dx % dy; dstate <= 3'b100; end
                    else dcnt <= dcnt - 1;
                end
                default: if (div_ack) dstate <= 3'b001;
            endcase
        end
    end

    // Event counters
    always @(posedge Clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (div_ack)   ack_cnt   <= ack_cnt + 1;
        if (cdb_valid) vld_cnt   <= vld_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] t);
        int b = 0;
        res_t e;
        @(negedge Clk);
        req_valid = 1'b1; req_x = x; req_y = y; req_tag = t;
        while (!req_ready && b < 200) begin @(negedge Clk); b++; end
        chk("push_ready", req_ready, 1);
        @(posedge Clk);
        e.tag = t;
        e.q = (y != 0) ? x / y : 8'hFF;
        e.r = (y != 0) ? x % y : x;
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic cmp_front();
        res_t e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("cdb_tag", cdb_tag, e.tag);
        chk("cdb_quotient", cdb_quotient, e.q);
        chk("cdb_remainder", cdb_remainder, e.r);
    endtask

    task automatic wait_valid();
        int b = 0;
        @(negedge Clk);
        while (!cdb_valid && b < 200) begin @(negedge Clk); b++; end
        chk("cdb_valid_seen", cdb_valid, 1);
    endtask

    task automatic wait_start();
        int b = 0;
        @(negedge Clk);
        while (!div_start && b < 200) begin @(negedge Clk); b++; end
        chk("div_start_seen", div_start, 1);
    endtask

    task automatic collect(input int n, input bit always_grant);
        int got = 0, b = 0;
        while (got < n && b < 2000) begin
            @(negedge Clk); b++;
            cdb_grant = always_grant ? 1'b1 : 1'($urandom_range(0, 1));
            if (cdb_valid && cdb_grant) begin cmp_front(); got++; end
        end
        chk("collect_count", got, n);
        @(negedge Clk);
        cdb_grant = 1'b0;
    endtask

    initial begin
        int s0, a0, v0, b, n;
        res_t e;

        // Reset values
        #12;
        chk("rst_div_start", div_start, 0);
        chk("rst_div_ack", div_ack, 0);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_quotient", cdb_quotient, 0);
        chk("rst_cdb_remainder", cdb_remainder, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge Clk) Reset = 1'b0;

        // T1: 100/7 tag 5, launch latency, single start and ack
        s0 = start_cnt; a0 = ack_cnt;
        push(8'd100, 8'd7, 3'd5);
        @(negedge Clk);
        chk("t1_no_start_yet", div_start, 0);
        @(negedge Clk);
        chk("t1_start", div_start, 1);
        chk("t1_xin", div_xin, 100);
        chk("t1_yin", div_yin, 7);
        chk("t1_tag_in", div_tag_in, 5);
        wait_valid();
        chk("t1_q", cdb_quotient, 14);
        chk("t1_r", cdb_remainder, 2);
        chk("t1_tag", cdb_tag, 5);
        collect(1, 1'b1);
        repeat (3) @(negedge Clk);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_acks", ack_cnt - a0, 1);

        // Randomized batches with random grant and divider latency
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
            collect(n, 1'b0);
        end

        // T2: stalled result plus four queued fills the FIFO; fifth is refused, order is kept
        cdb_grant = 1'b0;
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        wait_valid();
        for (int i = 0; i < 4; i++)
            push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        @(negedge Clk);
        req_valid = 1'b1; req_x = 8'd77; req_y = 8'd5; req_tag = 3'd6;
        #1 chk("t2_fifth_refused", req_ready, 0);
        repeat (3) @(negedge Clk);
        chk("t2_still_full", req_ready, 0);
        cdb_grant = 1'b1; b = 0;
        while (!div_start && b < 100) begin
            if (cdb_valid) cmp_front();
            @(negedge Clk); b++;
        end
        chk("t2_launch", div_start, 1);
        chk("t2_pop_no_room_yet", req_ready, 0);
        cdb_grant = 1'b0;
        @(negedge Clk);
        chk("t2_room_after_pop", req_ready, 1);
        @(posedge Clk);
        e.tag = 3'd6; e.q = 8'd15; e.r = 8'd2;
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
        collect(5, 1'b0);

        // T3: grant held low for 10 cycles in BCAST
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        wait_valid();
        a0 = ack_cnt;
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("t3_valid_held", cdb_valid, 1);
            chk("t3_tag_stable", cdb_tag, e.tag);
            chk("t3_q_stable", cdb_quotient, e.q);
            chk("t3_r_stable", cdb_remainder, e.r);
            chk("t3_no_ack", div_ack, 0);
        end
        @(negedge Clk);
        cdb_grant = 1'b1;
        #1 chk("t3_ack_on_grant", div_ack, 1);
        cmp_front();
        @(negedge Clk);
        cdb_grant = 1'b0;
        chk("t3_ack_one_cycle", div_ack, 0);
        chk("t3_valid_dropped", cdb_valid, 0);
        chk("t3_ack_count", ack_cnt - a0, 1);

        // T4: flush during WAIT drains the divider with no broadcast
        lat_fixed = 6;
        v0 = vld_cnt; a0 = ack_cnt;
        push(8'd200, 8'd3, 3'd2);
        void'(exp_q.pop_back());
        wait_start();
        @(negedge Clk);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        b = 0;
        while (ack_cnt == a0 && b < 50) begin @(negedge Clk); b++; end
        repeat (3) @(negedge Clk);
        chk("t4_drain_ack", ack_cnt - a0, 1);
        chk("t4_no_broadcast", vld_cnt - v0, 0);
        lat_fixed = 0;
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        collect(1, 1'b1);

        // Flush in BCAST with a request still queued
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        wait_valid();
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        @(negedge Clk);
        flush = 1'b1;
        #1;
        chk("fb_valid_drops", cdb_valid, 0);
        chk("fb_ack", div_ack, 1);
        @(negedge Clk);
        flush = 1'b0;
        chk("fb_ack_one_cycle", div_ack, 0);
        chk("fb_valid_low", cdb_valid, 0);
        exp_q.delete();
        s0 = start_cnt;
        repeat (10) @(negedge Clk);
        chk("fb_fifo_emptied", start_cnt - s0, 0);
        chk("fb_ready", req_ready, 1);

`ifdef DIV_ZERO_CHECK_EN
        // T5: divide by zero answered without the divider
        s0 = start_cnt; a0 = ack_cnt;
        push(8'd9, 8'd0, 3'd1);
        wait_valid();
        chk("t5_q", cdb_quotient, 8'hFF);
        chk("t5_r", cdb_remainder, 9);
        chk("t5_tag", cdb_tag, 1);
        collect(1, 1'b1);
        repeat (3) @(negedge Clk);
        chk("t5_no_start", start_cnt - s0, 0);
        chk("t5_no_ack", ack_cnt - a0, 0);
`endif

        // T6: asynchronous Reset in WAIT with a request queued
        lat_fixed = 20;
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        wait_start();
        @(negedge Clk);
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("t6_div_start", div_start, 0);
        chk("t6_div_ack", div_ack, 0);
        chk("t6_cdb_valid", cdb_valid, 0);
        chk("t6_cdb_tag", cdb_tag, 0);
        chk("t6_cdb_quotient", cdb_quotient, 0);
        chk("t6_cdb_remainder", cdb_remainder, 0);
        chk("t6_req_ready", req_ready, 1);
        @(negedge Clk) Reset = 1'b0;
        exp_q.delete();
        lat_fixed = 0;
        s0 = start_cnt;
        repeat (8) @(negedge Clk);
        chk("t6_fifo_empty", start_cnt - s0, 0);
        push(8'($urandom), 8'($urandom_range(1, 255)), 3'($urandom));
        collect(1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
